// File: rtl/control_sequencer_pkg.sv
// Shared SAP-U definitions: opcodes, control-word bit positions and flag bit positions.
// The control word is active-high internally and inverted at the pins for the _n strobes.
package control_sequencer_pkg;

  localparam int STEP_WIDTH_DEF = 3;
  localparam int LAST_STEP_DEF  = 4;
  localparam int CTRL_W         = 15;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_STA = 4'b0100,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  localparam int C_MI = 14;
  localparam int C_RI = 13;
  localparam int C_RO = 12;
  localparam int C_IO = 11;
  localparam int C_II = 10;
  localparam int C_AI = 9;
  localparam int C_AO = 8;
  localparam int C_EO = 7;
  localparam int C_BI = 6;
  localparam int C_OI = 5;
  localparam int C_CO = 4;
  localparam int C_J  = 3;
  localparam int C_FI = 2;
  localparam int C_SU = 1;
  localparam int C_CE = 0;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: (instr, step, flags) -> {step_end, ctrl}.
// ctrl bits are active-high "asserted" markers; unreachable steps emit nothing and end.
module microcode_rom
  import control_sequencer_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
  input  logic [3:0]            instr,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [1:0]            flags,
  output logic                  step_end,
  output logic [CTRL_W-1:0]     ctrl
);

  always_comb begin
    ctrl     = '0;
    step_end = 1'b0;
    case (int'(step))
      0: begin
        ctrl[C_CO] = 1'b1;
        ctrl[C_MI] = 1'b1;
      end
      1: begin
        ctrl[C_RO] = 1'b1;
        ctrl[C_II] = 1'b1;
        ctrl[C_CE] = 1'b1;
      end
      2: begin
        case (instr)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl[C_IO] = 1'b1;
            ctrl[C_MI] = 1'b1;
          end
          OP_LDI: begin
            ctrl[C_IO] = 1'b1;
            ctrl[C_AI] = 1'b1;
            step_end   = 1'b1;
          end
          OP_JMP: begin
            ctrl[C_IO] = 1'b1;
            ctrl[C_J]  = 1'b1;
            step_end   = 1'b1;
          end
          // Conditional jumps read the live flags, so a flag edge in T2 lands this cycle.
          OP_JC: begin
            ctrl[C_IO] = flags[FLAG_C];
            ctrl[C_J]  = flags[FLAG_C];
            step_end   = 1'b1;
          end
          OP_JZ: begin
            ctrl[C_IO] = flags[FLAG_Z];
            ctrl[C_J]  = flags[FLAG_Z];
            step_end   = 1'b1;
          end
          OP_OUT: begin
            ctrl[C_AO] = 1'b1;
            ctrl[C_OI] = 1'b1;
            step_end   = 1'b1;
          end
          default: step_end = 1'b1;
        endcase
      end
      3: begin
        case (instr)
          OP_LDA: begin
            ctrl[C_RO] = 1'b1;
            ctrl[C_AI] = 1'b1;
            step_end   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[C_RO] = 1'b1;
            ctrl[C_BI] = 1'b1;
          end
          OP_STA: begin
            ctrl[C_AO] = 1'b1;
            ctrl[C_RI] = 1'b1;
            step_end   = 1'b1;
          end
          default: step_end = 1'b1;
        endcase
      end
      4: begin
        step_end = 1'b1;
        if (instr == OP_ADD || instr == OP_SUB) begin
          ctrl[C_EO] = 1'b1;
          ctrl[C_AI] = 1'b1;
          ctrl[C_FI] = 1'b1;
          ctrl[C_SU] = (instr == OP_SUB);
        end
      end
      default: step_end = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-U control sequencer: microstep counter and halt latch around the microcode ROM.
// Reset and halt mask every strobe to its inactive level; step and hlt double as debug state.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int                  STEP_WIDTH = STEP_WIDTH_DEF,
  parameter logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(LAST_STEP_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            instr,
  input  logic [1:0]            flags,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  hlt,
  output logic                  mi_n,
  output logic                  ri_n,
  output logic                  ro_n,
  output logic                  io_n,
  output logic                  ii_n,
  output logic                  ai_n,
  output logic                  ao_n,
  output logic                  eo_n,
  output logic                  bi_n,
  output logic                  oi_n,
  output logic                  co_n,
  output logic                  j_n,
  output logic                  fi_n,
  output logic                  su,
  output logic                  ce
);

  logic [STEP_WIDTH-1:0] step_q, step_nxt;
  logic                  halted_q, halted_nxt;
  logic                  rom_end;
  logic [CTRL_W-1:0]     rom_ctrl;
  logic [CTRL_W-1:0]     ctrl;

  microcode_rom #(.STEP_WIDTH(STEP_WIDTH)) u_rom (
    .instr    (instr),
    .step     (step_q),
    .flags    (flags),
    .step_end (rom_end),
    .ctrl     (rom_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_nxt;
      halted_q <= halted_nxt;
    end
  end

  // LAST_STEP wraps even without an END marker so a bad ROM entry cannot run away.
  always_comb begin
    step_nxt   = step_q + 1'b1;
    halted_nxt = halted_q;
    if (halted_q || rom_end || step_q == LAST_STEP) begin
      step_nxt = '0;
    end
    if (!halted_q && step_q == STEP_WIDTH'(2) && instr == OP_HLT) begin
      halted_nxt = 1'b1;
    end
  end

  always_comb begin
    ctrl = rom_ctrl;
    if (reset || halted_q) begin
      ctrl = '0;
    end
    step = step_q;
    hlt  = halted_q && !reset;
    mi_n = ~ctrl[C_MI];
    ri_n = ~ctrl[C_RI];
    ro_n = ~ctrl[C_RO];
    io_n = ~ctrl[C_IO];
    ii_n = ~ctrl[C_II];
    ai_n = ~ctrl[C_AI];
    ao_n = ~ctrl[C_AO];
    eo_n = ~ctrl[C_EO];
    bi_n = ~ctrl[C_BI];
    oi_n = ~ctrl[C_OI];
    co_n = ~ctrl[C_CO];
    j_n  = ~ctrl[C_J];
    fi_n = ~ctrl[C_FI];
    su   = ctrl[C_SU];
    ce   = ctrl[C_CE];
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then randomized traffic, all checked
// cycle by cycle against an instruction-level model (lengths and per-step strobe sets).
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] instr;
  logic [1:0] flags;
  logic [2:0] step;
  logic       hlt;
  logic mi_n, ri_n, ro_n, io_n, ii_n, ai_n, ao_n, eo_n, bi_n, oi_n, co_n, j_n, fi_n, su, ce;

  control_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags), .step(step), .hlt(hlt),
    .mi_n(mi_n), .ri_n(ri_n), .ro_n(ro_n), .io_n(io_n), .ii_n(ii_n), .ai_n(ai_n),
    .ao_n(ao_n), .eo_n(eo_n), .bi_n(bi_n), .oi_n(oi_n), .co_n(co_n), .j_n(j_n),
    .fi_n(fi_n), .su(su), .ce(ce)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-local strobe masks, asserted = 1.
  localparam logic [14:0] MI = 15'h4000, RI = 15'h2000, RO = 15'h1000, IO = 15'h0800,
                          II = 15'h0400, AI = 15'h0200, AO = 15'h0100, EO = 15'h0080,
                          BI = 15'h0040, OI = 15'h0020, CO = 15'h0010, JJ = 15'h0008,
                          FI = 15'h0004, SU = 15'h0002, CE = 15'h0001;

  int n_vec  = 0;
  int n_fail = 0;

  int model_step   = 0;
  bit model_halted = 1'b0;

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0100: return 4;
      4'b0010, 4'b0011: return 5;
      default:          return 3;
    endcase
  endfunction

  function automatic logic [14:0] exp_word(input logic [3:0] op, input int t,
                                          input logic [1:0] fl);
    if (t == 0) return CO | MI;
    if (t == 1) return RO | II | CE;
    case (op)
      4'b0001: return (t == 2) ? (IO | MI) : (RO | AI);
      4'b0010: return (t == 2) ? (IO | MI) : (t == 3) ? (RO | BI) : (EO | AI | FI);
      4'b0011: return (t == 2) ? (IO | MI) : (t == 3) ? (RO | BI) : (EO | AI | FI | SU);
      4'b0100: return (t == 2) ? (IO | MI) : (AO | RI);
      4'b0101: return IO | AI;
      4'b0110: return IO | JJ;
      4'b0111: return fl[0] ? (IO | JJ) : 15'h0;
      4'b1000: return fl[1] ? (IO | JJ) : 15'h0;
      4'b1110: return AO | OI;
      default: return 15'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t obs=%h exp=%h instr=%b step_model=%0d", tag, $time, obs, exp,
             instr, model_step);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    logic [14:0] obs, exp;
    @(negedge clk);
    obs = {~mi_n, ~ri_n, ~ro_n, ~io_n, ~ii_n, ~ai_n, ~ao_n, ~eo_n, ~bi_n, ~oi_n, ~co_n,
           ~j_n, ~fi_n, su, ce};
    exp = (reset || model_halted) ? 15'h0 : exp_word(instr, model_step, flags);
    check("ctrl", 32'(obs), 32'(exp));
    check("step", 32'(step), 32'(model_step));
    check("hlt", 32'(hlt), 32'(model_halted && !reset));
    @(posedge clk);
    if (reset) begin
      model_step   = 0;
      model_halted = 1'b0;
    end else if (model_halted) begin
      model_step = 0;
    end else if (model_step == 2 && instr == 4'b1111) begin
      model_halted = 1'b1;
      model_step   = 0;
    end else begin
      model_step = (model_step + 1 == instr_len(instr)) ? 0 : model_step + 1;
    end
    #1;
  endtask

  // driver: run one full instruction from T0 back to T0
  task automatic run_instr(input logic [3:0] op, input logic [1:0] fl);
    instr = op;
    flags = fl;
    tick();
    for (int i = 0; i < 8 && model_step != 0; i++) tick();
    if (model_step != 0) check("instr_bound", 32'(model_step), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    instr = 4'b0000;
    flags = 2'b00;
    @(posedge clk); #1;
    tick();
    tick();
    reset = 1'b0;

    run_instr(4'b0001, 2'b00);
    run_instr(4'b0011, 2'b11);
    run_instr(4'b0010, 2'b00);
    run_instr(4'b0111, 2'b01);
    run_instr(4'b0111, 2'b00);
    run_instr(4'b1000, 2'b10);
    run_instr(4'b1000, 2'b00);
    run_instr(4'b0100, 2'b00);
    run_instr(4'b0101, 2'b00);
    run_instr(4'b0110, 2'b00);
    run_instr(4'b1110, 2'b00);
    run_instr(4'b0000, 2'b00);
    run_instr(4'b1010, 2'b00);

    // flag flips inside T2 of JC: decision follows the new value
    instr = 4'b0111;
    flags = 2'b00;
    tick();
    tick();
    flags = 2'b01;
    tick();

    // halt, stay frozen, then recover through reset
    run_instr(4'b1111, 2'b00);
    instr = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4 && model_step != 0; i++) tick();

    // reset lands in T3 of ADD
    instr = 4'b0010;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_instr(4'b0010, 2'b00);

    // randomized traffic; opcodes only change on instruction boundaries
    for (int c = 0; c < 600; c++) begin
      if (model_step == 0 && !model_halted) begin
        instr = ($urandom_range(0, 9) == 0) ? 4'b1111 : 4'($urandom_range(0, 14));
      end
      flags = 2'($urandom);
      reset = ($urandom_range(0, 40) == 0) || (model_halted && $urandom_range(0, 5) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
